// File: rtl/keypad_scanner.sv
// Row-scanned key matrix reader: 2-flop column sync, press/release debounce, first-key lock.
// Define KEYPAD_REPEAT_EN to add periodic one-cycle low pulses on ready while a key is held.
module keypad_scanner #(
  parameter int unsigned ROWS          = 4,
  parameter int unsigned COLS          = 5,
  parameter int unsigned SCAN_DIV      = 1000,
  parameter int unsigned DEBOUNCE_CNT  = 3,
  parameter int unsigned REPEAT_DWELLS = 500
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [COLS-1:0] col_n,
  output logic [ROWS-1:0] row_n,
  output logic [4:0]      keycode,
  output logic            ready
);

  localparam int unsigned RowW = (ROWS > 1) ? $clog2(ROWS) : 1;
  localparam int unsigned ColW = (COLS > 1) ? $clog2(COLS) : 1;
  localparam int unsigned CntW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int unsigned DebW = (DEBOUNCE_CNT > 0) ? $clog2(DEBOUNCE_CNT + 1) : 1;

  if (ROWS * COLS > 32) begin : gen_bad_matrix
    $error("keypad_scanner: ROWS*COLS must not exceed 32");
  end
  if (ROWS < 1 || COLS < 1 || SCAN_DIV < 1) begin : gen_bad_geometry
    $error("keypad_scanner: ROWS, COLS and SCAN_DIV must be at least 1");
  end
  if (DEBOUNCE_CNT < 1) begin : gen_bad_debounce
    $error("keypad_scanner: DEBOUNCE_CNT must be at least 1");
  end
  if (REPEAT_DWELLS < 1) begin : gen_bad_repeat
    $error("keypad_scanner: REPEAT_DWELLS must be at least 1");
  end

  typedef enum logic [1:0] {StScan, StDebounce, StHeld} state_e;

  state_e          state_q, state_d;
  logic [COLS-1:0] col_meta_q, col_sync_q;
  logic [CntW-1:0] dwell_q, dwell_d;
  logic [RowW-1:0] row_idx_q, row_idx_d;
  logic [ColW-1:0] cand_col_q, cand_col_d;
  logic [4:0]      cand_q, cand_d;
  logic [DebW-1:0] deb_q, deb_d;
  logic [4:0]      keycode_q, keycode_d;
  logic            ready_q, ready_d;

  logic            dwell_end;
  logic [RowW-1:0] row_next;
  logic            any_low;
  logic [ColW-1:0] low_col;
  logic [4:0]      scan_code;
  logic            cand_high;
  logic            deb_full;

`ifdef KEYPAD_REPEAT_EN
  localparam int unsigned RepW = (REPEAT_DWELLS > 1) ? $clog2(REPEAT_DWELLS) : 1;
  logic [RepW-1:0] rep_q, rep_d;
  logic            pulse_q, pulse_d;
`endif

  assign dwell_end = (dwell_q == CntW'(SCAN_DIV - 1));
  assign row_next  = (row_idx_q == RowW'(ROWS - 1)) ? '0 : row_idx_q + 1'b1;
  assign cand_high = col_sync_q[cand_col_q];
  assign deb_full  = (deb_q == DebW'(DEBOUNCE_CNT - 1));
  assign scan_code = 5'((32'(row_idx_q) * COLS) + 32'(low_col));

  // Lowest-index closed column wins when several are low on the driven row.
  always_comb begin
    any_low = 1'b0;
    low_col = '0;
    for (int c = COLS - 1; c >= 0; c--) begin
      if (!col_sync_q[c]) begin
        any_low = 1'b1;
        low_col = ColW'(c);
      end
    end
  end

  always_comb begin
    row_n            = '1;
    row_n[row_idx_q] = 1'b0;
  end

  always_comb begin
    state_d    = state_q;
    dwell_d    = dwell_end ? '0 : dwell_q + 1'b1;
    row_idx_d  = row_idx_q;
    cand_col_d = cand_col_q;
    cand_d     = cand_q;
    deb_d      = deb_q;
    keycode_d  = keycode_q;
    ready_d    = ready_q;
`ifdef KEYPAD_REPEAT_EN
    rep_d      = rep_q;
    pulse_d    = 1'b0;
`endif
    if (dwell_end) begin
      case (state_q)
        StScan: begin
          if (any_low) begin
            state_d    = StDebounce;
            cand_col_d = low_col;
            cand_d     = scan_code;
            deb_d      = '0;
          end else begin
            row_idx_d = row_next;
          end
        end
        StDebounce: begin
          if (!cand_high) begin
            if (deb_full) begin
              state_d   = StHeld;
              keycode_d = cand_q;
              ready_d   = 1'b1;
              deb_d     = '0;
`ifdef KEYPAD_REPEAT_EN
              rep_d     = '0;
`endif
            end else begin
              deb_d = deb_q + 1'b1;
            end
          end else begin
            state_d   = StScan;
            row_idx_d = row_next;
            deb_d     = '0;
          end
        end
        StHeld: begin
          // deb_q now counts consecutive open samples of the locked column.
          if (cand_high && deb_full) begin
            state_d   = StScan;
            ready_d   = 1'b0;
            row_idx_d = row_next;
            deb_d     = '0;
          end else begin
            deb_d = cand_high ? deb_q + 1'b1 : '0;
          end
`ifdef KEYPAD_REPEAT_EN
          // Release wins over a repeat pulse landing on the same dwell end.
          if (cand_high && deb_full) begin
            rep_d = '0;
          end else if (rep_q == RepW'(REPEAT_DWELLS - 1)) begin
            rep_d   = '0;
            pulse_d = 1'b1;
          end else begin
            rep_d = rep_q + 1'b1;
          end
`endif
        end
        default: begin
          state_d = StScan;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= StScan;
      col_meta_q <= '1;
      col_sync_q <= '1;
      dwell_q    <= '0;
      row_idx_q  <= '0;
      cand_col_q <= '0;
      cand_q     <= '0;
      deb_q      <= '0;
      keycode_q  <= '0;
      ready_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      col_meta_q <= col_n;
      col_sync_q <= col_meta_q;
      dwell_q    <= dwell_d;
      row_idx_q  <= row_idx_d;
      cand_col_q <= cand_col_d;
      cand_q     <= cand_d;
      deb_q      <= deb_d;
      keycode_q  <= keycode_d;
      ready_q    <= ready_d;
    end
  end

`ifdef KEYPAD_REPEAT_EN
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rep_q   <= '0;
      pulse_q <= 1'b0;
    end else begin
      rep_q   <= rep_d;
      pulse_q <= pulse_d;
    end
  end

  assign ready = ready_q & ~pulse_q;
`else
  assign ready = ready_q;
`endif

  assign keycode = keycode_q;

endmodule
